// File: rtl/dmem_arbiter.sv
// Round-robin arbiter from NUM_CORES core data ports onto one shared data memory.
// AMO read-modify-write pairs stay atomic through a lock, and a timeout releases an idle owner.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CORES    = 2,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CORES-1:0]              core_req,
  input  logic [NUM_CORES-1:0]              core_we,
  input  logic [NUM_CORES-1:0]              core_lock,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]   core_wdata,
  input  logic [NUM_CORES*DATA_WIDTH/8-1:0] core_mask,
  output logic [NUM_CORES-1:0]              core_gnt,
  output logic [NUM_CORES-1:0]              core_rvalid,
  output logic [DATA_WIDTH-1:0]             core_rdata,
  output logic                              lock_err,
  output logic                              mem_en,
  output logic                              mem_we_in,
  output logic [DATA_WIDTH-1:0]             mem_addr_in,
  output logic [DATA_WIDTH-1:0]             mem_data_in,
  output logic [DATA_WIDTH/8-1:0]           mem_mask_in,
  input  logic [DATA_WIDTH-1:0]             mem_data_out
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(NUM_CORES);
  localparam int CNT_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);
  localparam logic [PTR_W:0]   NUM_C   = (PTR_W + 1)'(NUM_CORES);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]     lk_own_reg, lk_own_next;
  logic [CNT_W-1:0]     lk_cnt_reg, lk_cnt_next;
  logic [NUM_CORES-1:0] pend_reg, pend_next;

  logic [DATA_WIDTH-1:0] addr_arr  [NUM_CORES];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_CORES];
  logic [MASK_W-1:0]     mask_arr  [NUM_CORES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign addr_arr[gi]  = core_addr[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wdata_arr[gi] = core_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign mask_arr[gi]  = core_mask[gi*MASK_W +: MASK_W];
    end
  endgenerate

  // Rotate requests so bit 0 is the core at rr_ptr; the lowest set bit wins.
  logic [2*NUM_CORES-1:0] req_dbl, req_shift;
  logic [NUM_CORES-1:0]   req_rot;
  logic                   rr_hit;
  logic [PTR_W:0]         rr_off, rr_sum;
  logic [PTR_W-1:0]       rr_idx;

  assign req_dbl   = {core_req, core_req};
  assign req_shift = req_dbl >> rr_ptr_reg;
  assign req_rot   = req_shift[NUM_CORES-1:0];

  always_comb begin : arbitrate
    rr_hit = 1'b0;
    rr_off = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rr_hit = 1'b1;
        rr_off = (PTR_W + 1)'(k);
      end
    end
    rr_sum = {1'b0, rr_ptr_reg} + rr_off;
    if (rr_sum >= NUM_C) begin
      rr_sum = rr_sum - NUM_C;
    end
    rr_idx = rr_sum[PTR_W-1:0];
  end

  logic             owner_req;
  logic             timeout_hit;
  logic             gnt_valid;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W:0]   gnt_inc;

  assign owner_req   = core_req[lk_own_reg];
  assign timeout_hit = (state_reg == LOCKED) && (lk_cnt_reg == CNT_MAX) && !owner_req;
  assign gnt_inc     = {1'b0, gnt_idx} + (PTR_W + 1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      lk_own_reg <= '0;
      lk_cnt_reg <= '0;
      pend_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      lk_own_reg <= lk_own_next;
      lk_cnt_reg <= lk_cnt_next;
      pend_reg   <= pend_next;
    end
  end

  always_comb begin : next_state
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    lk_own_next = lk_own_reg;
    lk_cnt_next = lk_cnt_reg;
    pend_next   = '0;
    if (gnt_valid && !core_we[gnt_idx]) begin
      pend_next[gnt_idx] = 1'b1;
    end
    case (state_reg)
      IDLE: begin
        if (gnt_valid) begin
          rr_ptr_next = (gnt_inc == NUM_C) ? '0 : gnt_inc[PTR_W-1:0];
          if (core_lock[gnt_idx]) begin
            state_next  = LOCKED;
            lk_own_next = gnt_idx;
            lk_cnt_next = '0;
          end
        end
      end
      LOCKED: begin
        // An owner request beats a timeout landing in the same cycle.
        if (gnt_valid) begin
          lk_cnt_next = '0;
          if (!core_lock[gnt_idx]) begin
            state_next = IDLE;
          end
        end else if (timeout_hit) begin
          state_next  = IDLE;
          lk_cnt_next = '0;
        end else if (lk_cnt_reg < CNT_MAX) begin
          lk_cnt_next = lk_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin : outputs
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (!rst) begin
      if (state_reg == LOCKED) begin
        gnt_valid = owner_req;
        gnt_idx   = lk_own_reg;
      end else begin
        gnt_valid = rr_hit;
        gnt_idx   = rr_idx;
      end
    end
    core_gnt = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      core_gnt[k] = gnt_valid && (gnt_idx == PTR_W'(k));
    end
    mem_en      = gnt_valid;
    mem_we_in   = 1'b0;
    mem_addr_in = '0;
    mem_data_in = '0;
    mem_mask_in = '0;
    if (gnt_valid) begin
      mem_we_in   = core_we[gnt_idx];
      mem_addr_in = addr_arr[gnt_idx];
      mem_data_in = wdata_arr[gnt_idx];
      mem_mask_in = mask_arr[gnt_idx];
    end
    lock_err    = timeout_hit && !rst;
    // A pending response is dropped if reset lands in its return cycle.
    core_rvalid = rst ? '0 : pend_reg;
    core_rdata  = mem_data_out;
  end

endmodule
